// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and encodings for the HI/LO multiply/divide unit.
// Contents:
//   mdu_op_t    - MULT/MULTU/DIV/DIVU, bit-compatible with the 2-bit op port
//   mdu_state_t - sequencer states IDLE/CALC/FIX
//   OP_*        - op encodings used by the ID control decode
//   helpers     - signedness / divide classification of an op
package mdu_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } mdu_state_t;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  function automatic logic op_is_signed(input mdu_op_t op);
    return (op == MULT) || (op == DIV);
  endfunction

  function automatic logic op_is_div(input mdu_op_t op);
    return (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: one radix-2 step of the iterative multiply/divide datapath.
// Ports:
//   is_div   in  1      0: shift-add multiply step, 1: restoring divide step
//   part_in  in  WIDTH  product high half (mul) / partial remainder (div)
//   low_in   in  WIDTH  multiplier/product low half (mul) / dividend->quotient (div)
//   b_in     in  WIDTH  multiplicand (mul) / divisor (div)
//   part_out out WIDTH  next part register value
//   low_out  out WIDTH  next low register value
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] part_in,
  input  logic [WIDTH-1:0] low_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] part_out,
  output logic [WIDTH-1:0] low_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    // Multiply: add b when the current multiplier LSB is set, then shift the
    // whole {part, low} pair right; the carry lands in the top of part.
    sum     = {1'b0, part_in} + (low_in[0] ? {1'b0, b_in} : '0);
    // Divide: bring the next dividend bit into the partial remainder and try
    // the subtraction at WIDTH+1 bits; bit WIDTH of diff is the borrow.
    shifted = {part_in, low_in[WIDTH-1]};
    diff    = shifted - {1'b0, b_in};

    part_out = sum[WIDTH:1];
    low_out  = {sum[0], low_in[WIDTH-1:1]};
    if (is_div) begin
      if (!diff[WIDTH]) begin
        part_out = diff[WIDTH-1:0];
        low_out  = {low_in[WIDTH-2:0], 1'b1};
      end else begin
        // Remainder stays below the divisor, so the top bit is always zero.
        part_out = shifted[WIDTH-1:0];
        low_out  = {low_in[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative HI/LO multiply/divide unit beside the EX stage.
// Owns HI/LO, serves MTHI/MTLO/MFHI/MFLO and stalls ID while busy.
// Ports:
//   clk      in  1      pipeline clock, rising edge
//   rst      in  1      asynchronous active-low reset
//   start    in  1      issue pulse for MULT/MULTU/DIV/DIVU
//   op       in  2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   op_a     in  WIDTH  rs operand (multiplicand/dividend)
//   op_b     in  WIDTH  rt operand (multiplier/divisor)
//   mthi     in  1      write mt_data to HI (idle only)
//   mtlo     in  1      write mt_data to LO (idle only)
//   mt_data  in  WIDTH  MTHI/MTLO data
//   hilo_rd  in  1      MFHI/MFLO in EX
//   flush    in  1      abort in-flight operation
//   hi, lo   out WIDTH  architectural HI/LO
//   busy     out 1      operation in flight
//   done     out 1      one-cycle pulse after HI/LO take a result
//   stall    out 1      busy & (start | mthi | mtlo | hilo_rd)
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] mt_data,
  input  logic             hilo_rd,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);
  import mdu_pkg::*;

  localparam int CW = $clog2(WIDTH + 1);

  mdu_state_t       state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  mdu_op_t          op_reg, op_next;
  logic             sign_a_reg, sign_a_next;
  logic             sign_b_reg, sign_b_next;
  logic             div_zero_reg, div_zero_next;
  logic [WIDTH-1:0] part_reg, part_next;
  logic [WIDTH-1:0] low_reg, low_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;
  logic             done_reg, done_next;

  logic [WIDTH-1:0]   part_step, low_step;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  mdu_op_t            op_in;
  logic               sa_in, sb_in;

  mdu_iter #(.WIDTH(WIDTH)) u_iter (
    .is_div   (op_is_div(op_reg)),
    .part_in  (part_reg),
    .low_in   (low_reg),
    .b_in     (b_reg),
    .part_out (part_step),
    .low_out  (low_step)
  );

  assign op_in = mdu_op_t'(op);
  assign sa_in = op_is_signed(op_in) & op_a[WIDTH-1];
  assign sb_in = op_is_signed(op_in) & op_b[WIDTH-1];

  // Sign correction of the unsigned core results. For a zero divisor the
  // remainder path holds |op_a|, so the remainder rule restores op_a itself.
  assign prod     = {part_reg, low_reg};
  assign prod_fix = (sign_a_reg ^ sign_b_reg) ? -prod : prod;
  assign quo_fix  = (sign_a_reg ^ sign_b_reg) ? -low_reg : low_reg;
  assign rem_fix  = sign_a_reg ? -part_reg : part_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      op_reg       <= MULT;
      sign_a_reg   <= 1'b0;
      sign_b_reg   <= 1'b0;
      div_zero_reg <= 1'b0;
      part_reg     <= '0;
      low_reg      <= '0;
      b_reg        <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      op_reg       <= op_next;
      sign_a_reg   <= sign_a_next;
      sign_b_reg   <= sign_b_next;
      div_zero_reg <= div_zero_next;
      part_reg     <= part_next;
      low_reg      <= low_next;
      b_reg        <= b_next;
      hi_reg       <= hi_next;
      lo_reg       <= lo_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    op_next       = op_reg;
    sign_a_next   = sign_a_reg;
    sign_b_next   = sign_b_reg;
    div_zero_next = div_zero_reg;
    part_next     = part_reg;
    low_next      = low_reg;
    b_next        = b_reg;
    hi_next       = hi_reg;
    lo_next       = lo_reg;
    done_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start && !flush) begin
          // Issue takes priority over a coincident MTHI/MTLO.
          state_next    = CALC;
          cnt_next      = '0;
          op_next       = op_in;
          sign_a_next   = sa_in;
          sign_b_next   = sb_in;
          div_zero_next = (op_b == '0);
          part_next     = '0;
          low_next      = sa_in ? -op_a : op_a;
          b_next        = sb_in ? -op_b : op_b;
        end else begin
          if (mthi) hi_next = mt_data;
          if (mtlo) lo_next = mt_data;
        end
      end
      CALC: begin
        if (flush) begin
          state_next = IDLE;
        end else begin
          part_next = part_step;
          low_next  = low_step;
          cnt_next  = cnt_reg + 1'b1;
          if (cnt_reg == CW'(WIDTH - 1)) state_next = FIX;
        end
      end
      FIX: begin
        state_next = IDLE;
        if (!flush) begin
          done_next = 1'b1;
          if (op_is_div(op_reg)) begin
            lo_next = div_zero_reg ? '1 : quo_fix;
            hi_next = rem_fix;
          end else begin
            hi_next = prod_fix[2*WIDTH-1:WIDTH];
            lo_next = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign hi    = hi_reg;
  assign lo    = lo_reg;
  assign done  = done_reg;
  assign busy  = (state_reg != IDLE);
  assign stall = busy & (start | mthi | mtlo | hilo_rd);

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and random checks of mul_div_unit against an
// arithmetic reference model (64-bit integer multiply/divide).
module tb_mul_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         mthi = 1'b0;
  logic         mtlo = 1'b0;
  logic [W-1:0] mt_data = '0;
  logic         hilo_rd = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] hi, lo;
  logic         busy, done, stall;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] cur_hi = '0;
  logic [W-1:0] cur_lo = '0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .op_a    (op_a),
    .op_b    (op_b),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .mt_data (mt_data),
    .hilo_rd (hilo_rd),
    .flush   (flush),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done),
    .stall   (stall)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on 64-bit values.
  function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] h, output logic [W-1:0] l);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h = '0;
    l = '0;
    case (o)
      2'b00: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      2'b01: begin p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0]; end
      2'b10: begin
        if (b == '0) begin h = a; l = '1; end
        else begin q = sa / sb; r = sa % sb; h = r[31:0]; l = q[31:0]; end
      end
      default: begin
        if (b == '0) begin h = a; l = '1; end
        else begin h = a % b; l = a / b; end
      end
    endcase
  endfunction

  // hz: 0 plain, 1 hilo_rd from busy cycle 10, 2 extra start at busy cycle 10,
  // 3 mthi asserted together with start.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hz, input string tag);
    logic [W-1:0] eh, el;
    int n, dones;
    model(o, a, b, eh, el);
    op = o; op_a = a; op_b = b; start = 1'b1;
    if (hz == 3) begin mthi = 1'b1; mt_data = 32'hDEAD_BEEF; end
    tick();
    start = 1'b0; mthi = 1'b0;
    n = 0; dones = 0;
    while (busy === 1'b1 && n < 100) begin
      if (n == 9 && hz == 1) hilo_rd = 1'b1;
      if (n == 9 && hz == 2) begin start = 1'b1; op = 2'b01; op_a = 32'd5; op_b = 32'd7; end
      #1;
      if ((hz == 1 && n >= 9) || (hz == 2 && n == 9)) check({tag, " stall"}, 64'(stall), 64'd1);
      if (done === 1'b1) dones++;
      n++;
      tick();
      start = 1'b0;
    end
    check({tag, " busy_len"}, 64'(n), 64'(W + 1));
    check({tag, " early_done"}, 64'(dones), 64'd0);
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " hi"}, 64'(hi), 64'(eh));
    check({tag, " lo"}, 64'(lo), 64'(el));
    if (hz == 1) begin
      check({tag, " stall_done_cycle"}, 64'(stall), 64'd0);
      hilo_rd = 1'b0;
    end
    cur_hi = eh;
    cur_lo = el;
    tick();
    check({tag, " done_pulse"}, 64'(done), 64'd0);
    check({tag, " idle_after"}, 64'(busy), 64'd0);
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h cycles=%0d [%s]", o, a, b, hi, lo, n, tag);
  endtask

  initial begin
    logic [1:0] ro;
    logic [W-1:0] ra, rb;
    int pulses;

    // Reset state
    rst = 1'b0; hilo_rd = 1'b1;
    tick(); tick();
    check("rst hi", 64'(hi), 64'd0);
    check("rst lo", 64'(lo), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst stall", 64'(stall), 64'd0);
    hilo_rd = 1'b0;
    rst = 1'b1;
    tick();

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu_max");
    check("multu_max hi const", 64'(hi), 64'h0000_0000_FFFF_FFFE);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0, "mult_neg");
    check("mult_neg lo const", 64'(lo), 64'h0000_0000_FFFF_FFF1);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, "div_neg");
    check("div_neg lo const", 64'(lo), 64'h0000_0000_FFFF_FFFD);
    run_op(2'b11, 32'd7, 32'd2, 1, "divu_hilo_rd");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 2, "div_min_neg1");
    check("div_min lo const", 64'(lo), 64'h0000_0000_8000_0000);
    run_op(2'b11, 32'h0000_1234, 32'd0, 3, "divu_zero_mthi");
    run_op(2'b10, 32'hFFFF_FF9C, 32'd0, 0, "div_zero_neg");
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0, "mult_min_min");

    // MTHI while idle
    mthi = 1'b1; mt_data = 32'h0000_CAFE;
    tick();
    mthi = 1'b0;
    check("mthi hi", 64'(hi), 64'h0000_CAFE);
    check("mthi lo kept", 64'(lo), 64'(cur_lo));
    cur_hi = 32'h0000_CAFE;
    $display("mthi data=%h -> hi=%h lo=%h", mt_data, hi, lo);

    // MTHI and MTLO together
    mthi = 1'b1; mtlo = 1'b1; mt_data = 32'h1234_5678;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    check("mthilo hi", 64'(hi), 64'h1234_5678);
    check("mthilo lo", 64'(lo), 64'h1234_5678);
    cur_hi = 32'h1234_5678; cur_lo = 32'h1234_5678;
    $display("mthi+mtlo data=%h -> hi=%h lo=%h", mt_data, hi, lo);

    // start together with flush in IDLE is ignored
    op = 2'b01; op_a = 32'd3; op_b = 32'd3; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check("start_flush busy", 64'(busy), 64'd0);
    tick();
    check("start_flush done", 64'(done), 64'd0);
    check("start_flush hi", 64'(hi), 64'(cur_hi));
    $display("start+flush in idle -> busy=%b hi=%h lo=%h", busy, hi, lo);

    // flush in CALC
    op = 2'b01; op_a = 32'd7; op_b = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("flush pre busy", 64'(busy), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    check("flush hi", 64'(hi), 64'(cur_hi));
    check("flush lo", 64'(lo), 64'(cur_lo));
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) pulses++;
      tick();
    end
    check("flush no_done", 64'(pulses), 64'd0);
    check("flush hi later", 64'(hi), 64'(cur_hi));
    $display("flush in calc -> busy=%b hi=%h lo=%h done_pulses=%0d", busy, hi, lo, pulses);

    // Random operations against the model
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 9))
        0: rb = '0;
        1: rb = $urandom_range(1, 15);
        2: rb = '1;
        3: rb = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, 0, "random");
    end

    // Asynchronous reset mid-operation
    mthi = 1'b1; mtlo = 1'b1; mt_data = 32'hA5A5_5A5A;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    op = 2'b00; op_a = 32'd123; op_b = 32'd456; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    check("pre_rst hi", 64'(hi), 64'hA5A5_5A5A);
    rst = 1'b0;
    #1;
    check("async_rst hi", 64'(hi), 64'd0);
    check("async_rst lo", 64'(lo), 64'd0);
    check("async_rst busy", 64'(busy), 64'd0);
    $display("async reset mid-op -> hi=%h lo=%h busy=%b", hi, lo, busy);
    tick();
    rst = 1'b1;
    tick(); tick();
    check("post_rst done", 64'(done), 64'd0);
    check("post_rst busy", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
